registro_llamadas: RTL and testbench
====================================

REGISTRO_LLAMADAS -- requirements
Module: registro_llamadas

Interface
REQ-001 Parameter DEB_CYCLES, default 4, number of consecutive stable samples required to accept a button level change (legal range 2..15).
REQ-002 Parameter TMO_CYCLES, default 64, maximum cycles a request is served before timeout (legal range 2..255).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_a  input  1  raw, asynchronous, bouncing call button for floor A (floor code 2'b00).
REQ-006 btn_b  input  1  raw, asynchronous, bouncing call button for floor B (floor code 2'b01).
REQ-007 piso  input  2  current floor fed back from the elevator controller; 2'b00 = A, 2'b01 = B, 2'b10/2'b11 = between floors.
REQ-008 A  output  1  registered request line to the elevator controller, floor A.
REQ-009 B  output  1  registered request line to the elevator controller, floor B.
REQ-010 pend  output  2  registered pending flags {B,A}.
REQ-011 err  output  1  registered sticky timeout flag.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Per button, a 4-bit counter SHALL increment while the synchronized level differs from the debounced level, clear to 0 when they match, and the debounced level SHALL update (counter clears) on the edge where the counter would reach DEB_CYCLES.
REQ-014 A press event SHALL be a 0->1 update of the debounced level; 1->0 updates generate no event.
REQ-015 On a press event, the matching pend bit SHALL set on the same edge the debounced level updates, unless piso equals that floor's code in that cycle, in which case the press SHALL be discarded.
REQ-016 A press on an already-pending floor SHALL have no effect and SHALL NOT alter arbitration order.
REQ-017 An order bit SHALL record which pend bit set first; if both set on the same edge, A is first.
REQ-018 FSM states: IDLE, SERV_A, SERV_B; encoding is free.
REQ-019 IDLE: if no pend, stay; if exactly one pend, go to its SERV state; if both, go to SERV of the first-arrived floor.
REQ-020 SERV_X: A (or B) SHALL be 1 for exactly the cycles the FSM is in SERV_A (SERV_B); A and B SHALL never be 1 together.
REQ-021 SERV_X: on the edge where piso equals X's code, clear pend X, and go to SERV of the other floor if pending, else IDLE.
REQ-022 A timeout counter SHALL clear on SERV entry and increment each cycle in SERV; at TMO_CYCLES it SHALL clear pend X, set err, and take the REQ-021 transition.
REQ-023 err SHALL remain 1 until reset.
REQ-024 Latency: with btn_a held high from before edge 1 and no bounce, pend[0] SHALL rise after edge DEB_CYCLES+2 and A after edge DEB_CYCLES+3.
REQ-025 piso codes 2'b10/2'b11 SHALL never clear any pend bit.

Reset
REQ-026 reset=1 SHALL immediately force A=0, B=0, pend=2'b00, err=0, FSM=IDLE, all counters, synchronizers, debounced levels and order bit to 0, regardless of clk.
REQ-027 Reset asserted mid-service SHALL drop all pending requests; button levels held high through reset deassertion SHALL be re-debounced and generate a new press.

Verification
REQ-028 DEB_CYCLES=4, piso=2'b01, btn_a held 1 -> pend=2'b01 after edge 6, A=1 after edge 7; piso->2'b00 -> A=0, pend=2'b00 on next edge.
REQ-029 btn_b toggling every cycle for 20 cycles, then 0 -> pend stays 2'b00, B stays 0.
REQ-030 btn_b pressed, 10 cycles later btn_a pressed, piso=2'b10 -> B serviced first; piso=2'b01 -> B=0, A=1 next edge; piso=2'b00 -> IDLE, pend=2'b00.
REQ-031 btn_a pressed while piso=2'b00 -> press discarded, pend=2'b00, A=0.
REQ-032 TMO_CYCLES=8, btn_a pressed, piso stuck 2'b10 -> A high exactly 8 cycles, then A=0, pend=2'b00, err=1 until reset.
REQ-033 reset pulsed while in SERV_A with B pending -> A=0, B=0, pend=2'b00 asynchronously; no output activity after deassertion until a new debounced press.

Source files
------------

// File: rtl/registro_llamadas.sv
// Two-floor call register: debounces the floor buttons, latches pending calls
// and serves them one at a time in arrival order, with a per-call service timeout.
module registro_llamadas #(
    parameter int DEB_CYCLES = 4,
    parameter int TMO_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic [1:0] piso,
    output logic       A,
    output logic       B,
    output logic [1:0] pend,
    output logic       err
);

    localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SERV_A = 2'b01,
        SERV_B = 2'b10
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] press;
    logic [1:0] at_floor;

    assign btn_raw  = {btn_b, btn_a};
    assign at_floor = {piso == 2'b01, piso == 2'b00};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic       sync1_reg;
            logic       sync2_reg;
            logic       deb_reg;
            logic [3:0] cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    cnt_reg   <= 4'd0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != deb_reg) begin
                        if (cnt_reg == DEB_LAST) begin
                            deb_reg <= sync2_reg;
                            cnt_reg <= 4'd0;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end else begin
                        cnt_reg <= 4'd0;
                    end
                end
            end

            // Only the rising update of the debounced level is a call.
            assign press[gi] = sync2_reg & ~deb_reg & (cnt_reg == DEB_LAST);
        end
    endgenerate

    state_t     state_reg, state_next;
    logic [1:0] pend_reg, pend_next;
    logic [1:0] clr, set;
    logic       order_reg, order_next;
    logic       err_reg, err_next;
    logic [7:0] tmo_reg, tmo_next;
    logic       tmo_hit;

    assign tmo_hit = (tmo_reg == TMO_LAST);

    always_comb begin
        state_next = state_reg;
        clr        = 2'b00;
        err_next   = err_reg;
        tmo_next   = tmo_reg + 8'd1;
        case (state_reg)
            IDLE: begin
                tmo_next = 8'd0;
                if (pend_reg == 2'b11)
                    state_next = order_reg ? SERV_B : SERV_A;
                else if (pend_reg[0])
                    state_next = SERV_A;
                else if (pend_reg[1])
                    state_next = SERV_B;
            end
            SERV_A: begin
                if (at_floor[0] || tmo_hit) begin
                    clr[0]     = 1'b1;
                    err_next   = err_reg | ~at_floor[0];
                    tmo_next   = 8'd0;
                    state_next = pend_reg[1] ? SERV_B : IDLE;
                end
            end
            SERV_B: begin
                if (at_floor[1] || tmo_hit) begin
                    clr[1]     = 1'b1;
                    err_next   = err_reg | ~at_floor[1];
                    tmo_next   = 8'd0;
                    state_next = pend_reg[0] ? SERV_A : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                tmo_next   = 8'd0;
            end
        endcase
    end

    // order_reg = 1 means B is the older of two pending calls.
    always_comb begin
        set        = press & ~pend_reg & ~at_floor;
        pend_next  = (pend_reg & ~clr) | set;
        order_next = order_reg;
        if (pend_next == 2'b11) begin
            if (set == 2'b01)
                order_next = 1'b1;
            else if (set != 2'b00)
                order_next = 1'b0;
        end else begin
            order_next = pend_next[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            pend_reg  <= 2'b00;
            order_reg <= 1'b0;
            err_reg   <= 1'b0;
            tmo_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            order_reg <= order_next;
            err_reg   <= err_next;
            tmo_reg   <= tmo_next;
        end
    end

    assign A    = (state_reg == SERV_A);
    assign B    = (state_reg == SERV_B);
    assign pend = pend_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_registro_llamadas.sv
// Bench for registro_llamadas: directed scenarios plus random bouncing buttons,
// checked cycle by cycle against a call-list reference model through a scoreboard queue.
module tb_registro_llamadas;

    localparam int DEB     = 4;
    localparam int TMO     = 8;
    localparam int LOG_MAX = 8191;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_a;
    logic       btn_b;
    logic [1:0] piso;
    logic       A;
    logic       B;
    logic [1:0] pend;
    logic       err;

    registro_llamadas #(.DEB_CYCLES(DEB), .TMO_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .btn_a (btn_a),
        .btn_b (btn_b),
        .piso  (piso),
        .A     (A),
        .B     (B),
        .pend  (pend),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       a;
        logic       b;
        logic [1:0] pend;
        logic       err;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: raw samples indexed by edge since reset, debounced
    // levels, and the pending calls as a list in arrival order.
    bit raw_log [2][LOG_MAX+1];
    int m_edge;
    bit m_deb [2];
    int m_run [2];
    int m_list[$];
    bit m_serving;
    int m_elapsed;
    bit m_err;

    function automatic bit is_pending(input int f);
        foreach (m_list[k])
            if (m_list[k] == f) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_edge    = 0;
        m_deb     = '{1'b0, 1'b0};
        m_run     = '{0, 0};
        m_list.delete();
        m_serving = 1'b0;
        m_elapsed = 0;
        m_err     = 1'b0;
    endtask

    task automatic model_edge(input bit ra, input bit rb, input logic [1:0] p);
        bit   pre   [2];
        bit   press [2];
        bit   seen;
        bit   arrived;
        obs_t e;
        m_edge++;
        if (m_edge > LOG_MAX) begin
            $display("FAIL model_log edge=%0d limit=%0d", m_edge, LOG_MAX);
            $fatal(1);
        end
        raw_log[0][m_edge] = ra;
        raw_log[1][m_edge] = rb;
        for (int f = 0; f < 2; f++) pre[f] = is_pending(f);

        if (m_serving) begin
            m_elapsed++;
            arrived = (int'(p) == m_list[0]);
            if (arrived || m_elapsed == TMO) begin
                if (!arrived) m_err = 1'b1;
                void'(m_list.pop_front());
                m_elapsed = 0;
                m_serving = (m_list.size() != 0);
            end
        end else if (m_list.size() != 0) begin
            m_serving = 1'b1;
            m_elapsed = 0;
        end

        // The logic at edge n sees the raw level sampled two edges earlier.
        for (int f = 0; f < 2; f++) begin
            seen     = (m_edge >= 3) ? raw_log[f][m_edge-2] : 1'b0;
            press[f] = 1'b0;
            if (seen != m_deb[f]) begin
                m_run[f]++;
                if (m_run[f] == DEB) begin
                    m_deb[f] = seen;
                    m_run[f] = 0;
                    press[f] = seen;
                end
            end else begin
                m_run[f] = 0;
            end
        end
        for (int f = 0; f < 2; f++)
            if (press[f] && int'(p) != f && !pre[f]) m_list.push_back(f);

        e.a    = m_serving && (m_list[0] == 0);
        e.b    = m_serving && (m_list[0] == 1);
        e.pend = {is_pending(1), is_pending(0)};
        e.err  = m_err;
        exp_q.push_back(e);
    endtask

    // Monitor: compares DUT outputs every cycle against the queued expectation.
    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({A, B, pend, err} !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got A=%b B=%b pend=%b err=%b expected A=%b B=%b pend=%b err=%b",
                         $time, A, B, pend, err, e.a, e.b, e.pend, e.err);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp_v);
        end else begin
            $display("check %s = %0d", name, act);
        end
    endtask

    task automatic cyc(input logic ra, input logic rb, input logic [1:0] p);
        btn_a = ra;
        btn_b = rb;
        piso  = p;
        @(posedge clk);
        model_edge(ra, rb, p);
        #2;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_A", int'(A), 0);
        check("rst_B", int'(B), 0);
        check("rst_pend", int'(pend), 0);
        check("rst_err", int'(err), 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int         hi_cnt;
        logic       ra;
        logic       rb;
        logic [1:0] p;
        int         hold_a;
        int         hold_b;

        reset = 1'b1;
        btn_a = 1'b0;
        btn_b = 1'b0;
        piso  = 2'b10;
        model_reset();
        #1;
        check("init_A", int'(A), 0);
        check("init_pend", int'(pend), 0);
        check("init_err", int'(err), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Press latency and arrival at A.
        for (int c = 1; c <= 7; c++) begin
            cyc(1'b1, 1'b0, 2'b01);
            if (c == 5) check("lat_pend_e5", int'(pend), 0);
            if (c == 6) begin
                check("lat_pend_e6", int'(pend), 1);
                check("lat_A_e6", int'(A), 0);
            end
            if (c == 7) check("lat_A_e7", int'(A), 1);
        end
        cyc(1'b1, 1'b0, 2'b00);
        check("arrive_A", int'(A), 0);
        check("arrive_pend", int'(pend), 0);
        repeat (8) cyc(1'b0, 1'b0, 2'b01);

        // Button B bouncing every cycle never registers.
        hi_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1'b0, logic'(c % 2), 2'b10);
            hi_cnt += int'(B);
        end
        repeat (10) begin
            cyc(1'b0, 1'b0, 2'b10);
            hi_cnt += int'(B);
        end
        check("bounce_B_cycles", hi_cnt, 0);
        check("bounce_pend", int'(pend), 0);

        // B first, A later; serve B, then A.
        for (int c = 1; c <= 10; c++) cyc(logic'(c >= 4), 1'b1, 2'b10);
        check("order_B_served", int'(B), 1);
        check("order_A_idle", int'(A), 0);
        check("order_pend_both", int'(pend), 3);
        cyc(1'b1, 1'b1, 2'b01);
        check("order_then_A", int'(A), 1);
        check("order_B_done", int'(B), 0);
        check("order_pend_a", int'(pend), 1);
        cyc(1'b1, 1'b1, 2'b00);
        check("order_A_done", int'(A), 0);
        check("order_pend_none", int'(pend), 0);
        repeat (8) cyc(1'b0, 1'b0, 2'b10);

        // Press at the current floor is discarded.
        hi_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(1'b1, 1'b0, 2'b00);
            hi_cnt += int'(A);
        end
        check("here_A_cycles", hi_cnt, 0);
        check("here_pend", int'(pend), 0);
        repeat (8) cyc(1'b0, 1'b0, 2'b10);

        // Timeout: elevator never arrives.
        hi_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            cyc(1'b1, 1'b0, 2'b10);
            hi_cnt += int'(A);
        end
        check("tmo_A_cycles", hi_cnt, TMO);
        check("tmo_A_low", int'(A), 0);
        check("tmo_pend", int'(pend), 0);
        check("tmo_err", int'(err), 1);
        repeat (10) cyc(1'b0, 1'b0, 2'b10);
        check("tmo_err_sticky", int'(err), 1);
        pulse_reset();

        // Reset while serving A with B pending; held buttons re-debounce.
        for (int c = 0; c < 8; c++) cyc(1'b1, 1'b1, 2'b10);
        check("mid_A", int'(A), 1);
        check("mid_pend", int'(pend), 3);
        pulse_reset();
        hi_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            cyc(1'b1, 1'b1, 2'b10);
            hi_cnt += int'(A) + int'(B) + int'(pend);
        end
        check("post_rst_quiet", hi_cnt, 0);
        cyc(1'b1, 1'b1, 2'b10);
        check("post_rst_pend", int'(pend), 3);
        cyc(1'b1, 1'b1, 2'b10);
        check("post_rst_A", int'(A), 1);
        pulse_reset();

        // Random bouncing buttons, wandering floor, occasional reset.
        ra     = 1'b0;
        rb     = 1'b0;
        p      = 2'b10;
        hold_a = 1;
        hold_b = 1;
        for (int c = 0; c < 3000; c++) begin
            hold_a--;
            if (hold_a <= 0) begin
                ra     = ~ra;
                hold_a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(5, 14));
            end
            hold_b--;
            if (hold_b <= 0) begin
                rb     = ~rb;
                hold_b = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(5, 14));
            end
            if ($urandom_range(0, 5) == 0) p = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) pulse_reset();
            cyc(ra, rb, p);
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
